line_buffer_3row: RTL and testbench

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

---
 rtl/line_buffer_3row.sv | 92 +++++++++
 tb/tb_line_buffer_3row.sv | 108 ++++++++++
 2 files changed

// File: rtl/line_buffer_3row.sv
// Three-row vertical window generator: two line memories plus the live pixel feed a 3x3 filter.
// Optional LB_BORDER_REPLICATE_EN replicates the top rows so that en is high from row 0.
module line_buffer_3row #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic       en,
  output logic       eol,
  output logic       eof
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col, col_e;
  logic [RW-1:0] row, row_e;
  logic [7:0]    line_a [IMG_W];
  logic [7:0]    line_b [IMG_W];
  logic [7:0]    rd_a, rd_b, nr0, nr1;
  logic          last_col, last_row, nen;

  // sof forces position (0,0) for this pixel regardless of counter state
  always_comb begin
    col_e    = sof ? '0 : col;
    row_e    = sof ? '0 : row;
    rd_a     = line_a[col_e];
    rd_b     = line_b[col_e];
    last_col = (col_e == CW'(IMG_W - 1));
    last_row = (row_e == RW'(IMG_H - 1));
  end

`ifdef LB_BORDER_REPLICATE_EN
  always_comb begin
    nen = 1'b1;
    nr0 = rd_b;
    nr1 = rd_a;
    if (row_e == '0) begin
      nr0 = pix_in;
      nr1 = pix_in;
    end else if (row_e == RW'(1)) begin
      nr0 = rd_a;
    end
  end
`else
  // rows not yet filled this frame read as 0 so stale memory never leaks out
  always_comb begin
    nen = (row_e >= RW'(2));
    nr0 = nen ? rd_b : 8'd0;
    nr1 = (row_e != '0) ? rd_a : 8'd0;
  end
`endif

  // line memories: read-before-write, contents intentionally not reset
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line_b[col_e] <= rd_a;
      line_a[col_e] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      r0  <= '0;
      r1  <= '0;
      r2  <= '0;
      en  <= 1'b0;
      eol <= 1'b0;
      eof <= 1'b0;
    end else begin
      en  <= pix_valid & nen;
      eol <= pix_valid & last_col;
      eof <= pix_valid & last_col & last_row;
      if (pix_valid) begin
        r0  <= nr0;
        r1  <= nr1;
        r2  <= pix_in;
        col <= last_col ? '0 : col_e + CW'(1);
        if (last_col) row <= last_row ? '0 : row_e + RW'(1);
        else          row <= row_e;
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row at IMG_W=4, IMG_H=3; follows LB_BORDER_REPLICATE_EN too.
module tb_line_buffer_3row;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       sof = 1'b0;
  logic [7:0] r0, r1, r2;
  logic       en, eol, eof;

  int checks = 0;
  int errors = 0;
  int last0 = 0, last1 = 0, last2 = 0;

  line_buffer_3row #(.IMG_W(4), .IMG_H(3)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .r0(r0), .r1(r1), .r2(r2), .en(en), .eol(eol), .eof(eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // one accepted pixel; a1/a2 are the hand-derived pixels one/two lines above
  task automatic px(input int v, input bit s, input int c, input int rw,
                    input int a1, input int a2);
    int e0, e1, een;
`ifdef LB_BORDER_REPLICATE_EN
    een = 1;
    if (rw == 0)      begin e0 = v;  e1 = v;  end
    else if (rw == 1) begin e0 = a1; e1 = a1; end
    else              begin e0 = a2; e1 = a1; end
`else
    een = (rw >= 2) ? 1 : 0;
    e0  = (rw >= 2) ? a2 : 0;
    e1  = (rw >= 1) ? a1 : 0;
`endif
    @(negedge clk);
    pix_in = 8'(v); pix_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    chk("en",  int'(en),  een);
    chk("r0",  int'(r0),  e0);
    chk("r1",  int'(r1),  e1);
    chk("r2",  int'(r2),  v);
    chk("eol", int'(eol), (c == 3) ? 1 : 0);
    chk("eof", int'(eof), (c == 3 && rw == 2) ? 1 : 0);
    last0 = e0; last1 = e1; last2 = v;
  endtask

  task automatic gap();
    @(negedge clk);
    pix_valid = 1'b0; sof = 1'b0; pix_in = 8'hA5;
    @(posedge clk); #1;
    chk("gap_en",  int'(en),  0);
    chk("gap_eol", int'(eol), 0);
    chk("gap_eof", int'(eof), 0);
    chk("gap_r0",  int'(r0),  last0);
    chk("gap_r1",  int'(r1),  last1);
    chk("gap_r2",  int'(r2),  last2);
  endtask

  task automatic frame(input int base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      px(base + i, i == 0, i % 4, i / 4, base + i - 4, base + i - 8);
      if (gaps) gap();
    end
  endtask

  initial begin
    #1;
    chk("rst_r0", int'(r0), 0); chk("rst_r1", int'(r1), 0); chk("rst_r2", int'(r2), 0);
    chk("rst_en", int'(en), 0); chk("rst_eol", int'(eol), 0); chk("rst_eof", int'(eof), 0);
    @(negedge clk); rst = 1'b0;

    // continuous frame 1..12, then back-to-back frame 101..112
    frame(1, 12, 1'b0);
    frame(101, 12, 1'b0);
    // same stream with a gap after every pixel
    frame(1, 12, 1'b1);

    // mid-frame restart: sof on pixel 6 (value 50)
    frame(1, 5, 1'b0);
    for (int j = 0; j < 12; j++)
      px(50 + j, j == 0, j % 4, j / 4, 50 + j - 4, 50 + j - 8);

    // reset after pixel 7 aborts the frame; restart without sof
    frame(1, 7, 1'b0);
    @(negedge clk);
    pix_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_r0", int'(r0), 0); chk("mid_rst_r1", int'(r1), 0);
    chk("mid_rst_r2", int'(r2), 0); chk("mid_rst_en", int'(en), 0);
    chk("mid_rst_eol", int'(eol), 0); chk("mid_rst_eof", int'(eof), 0);
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 12; j++)
      px(200 + j, 1'b0, j % 4, j / 4, 200 + j - 4, 200 + j - 8);

    @(negedge clk); pix_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
